// File: rtl/rtc_pkg.sv
// Purpose: shared constants for the RTC time-read sequencer (register map, FSM encoding, bus idle word).
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package rtc_pkg;

  // RTC register addresses, in read order: seconds, minutes, hours.
  localparam logic [7:0] ADDR_SEG  = 8'h21;
  localparam logic [7:0] ADDR_MIN  = 8'h22;
  localparam logic [7:0] ADDR_HORA = 8'h23;

  // Index of the last register read in one transaction (hours).
  localparam logic [1:0] LAST_IDX = 2'd2;

  // Sequencer states. Explicit encoding keeps it stable across tools.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_TURN = 3'd2,
    ST_READ = 3'd3,
    ST_GAP  = 3'd4,
    ST_DONE = 3'd5,
    ST_ARM  = 3'd6
  } state_t;

  // Everything the sequencer drives onto the RTC bus, registered as one word.
  typedef struct packed {
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       ad_sel;
    logic       ad_oe;
    logic [7:0] ad_out;
  } bus_t;

  // Bus word with every strobe released and the AD driver off.
  localparam bus_t BUS_IDLE = '{
    cs_n:   1'b1,
    wr_n:   1'b1,
    rd_n:   1'b1,
    ad_sel: 1'b0,
    ad_oe:  1'b0,
    ad_out: 8'h00
  };

  // Register address for a given read index (0 = seconds, 1 = minutes, 2 = hours).
  function automatic logic [7:0] rtc_addr(input logic [1:0] idx);
    logic [7:0] a;
    case (idx)
      2'd0:    a = ADDR_SEG;
      2'd1:    a = ADDR_MIN;
      default: a = ADDR_HORA;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/contador_fase.sv
// Purpose: 8-bit phase timer; loaded with (width-1) on state entry, counts down and holds at zero.
// Latency: done rises the cycle the count reaches zero; a load takes effect on the next edge.
// Backpressure: none; load always wins over counting.
module contador_fase (
  input  logic       CLK,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: reload on request, otherwise decrement and saturate at zero (never wraps).
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == 8'd0);

endmodule

// File: rtl/lectura_rtc.sv
// Purpose: reads seconds/minutes/hours from a multiplexed-AD RTC on one whileT request, reports with finwt.
// Latency: whileT seen in IDLE -> finwt 3*(2*PULSE+2*GAP) edges later (36 at defaults), one cycle wide.
// Backpressure: none; a started read always completes, and ARM blocks a restart until whileT drops.
module lectura_rtc
  import rtc_pkg::*;
#(
  parameter int PULSE = 4,  // strobe low width in CLK cycles, 1..255
  parameter int GAP   = 2   // turnaround / gap width in CLK cycles, 1..255
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       whileT,
  output logic       finwt,
  output logic       busy,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       ad_sel,
  output logic       ad_oe,
  output logic [7:0] ad_out,
  input  logic [7:0] ad_in,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora
);

  // Timer reload values: a phase of width W runs W cycles, so the counter starts at W-1.
  localparam logic [7:0] PULSE_LD = 8'(PULSE - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  bus_t       bus_q, bus_d;
  logic       finwt_q, finwt_d;
  logic       busy_q, busy_d;
  logic [7:0] seg_q, seg_d;
  logic [7:0] min_q, min_d;
  logic [7:0] hora_q, hora_d;

  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_done;

  contador_fase u_contador_fase (
    .CLK      (CLK),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // State, index, registered bus outputs and captured time registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      bus_q   <= BUS_IDLE;
      finwt_q <= 1'b0;
      busy_q  <= 1'b0;
      seg_q   <= 8'h00;
      min_q   <= 8'h00;
      hora_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bus_q   <= bus_d;
      finwt_q <= finwt_d;
      busy_q  <= busy_d;
      seg_q   <= seg_d;
      min_q   <= min_d;
      hora_q  <= hora_d;
    end
  end

  // Next state, read index and data capture; each timed phase ends when the timer reaches zero.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seg_d   = seg_q;
    min_d   = min_q;
    hora_d  = hora_q;
    case (state_q)
      ST_IDLE: begin
        if (whileT) begin
          state_d = ST_ADDR;
          idx_d   = 2'd0;
        end
      end
      ST_ADDR: begin
        if (tmr_done) state_d = ST_TURN;
      end
      ST_TURN: begin
        if (tmr_done) state_d = ST_READ;
      end
      ST_READ: begin
        // Last READ cycle: the RTC has had the full strobe width to settle ad_in.
        if (tmr_done) begin
          state_d = ST_GAP;
          case (idx_q)
            2'd0:    seg_d  = ad_in;
            2'd1:    min_d  = ad_in;
            default: hora_d = ad_in;
          endcase
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ADDR;
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_ARM;
      end
      ST_ARM: begin
        // Wait for the request to be withdrawn so one assertion gives one read.
        if (!whileT) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Timer reload on every state change, sized by the phase being entered.
  always_comb begin
    tmr_load = (state_d != state_q);
    case (state_d)
      ST_ADDR, ST_READ: tmr_val = PULSE_LD;
      ST_TURN, ST_GAP:  tmr_val = GAP_LD;
      default:          tmr_val = 8'd0;
    endcase
  end

  // Outputs decoded from the state being entered, so each flop takes its new value on the entry edge.
  always_comb begin
    bus_d   = BUS_IDLE;
    finwt_d = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
    case (state_d)
      ST_ADDR: begin
        bus_d.cs_n   = 1'b0;
        bus_d.wr_n   = 1'b0;
        bus_d.ad_sel = 1'b0;
        bus_d.ad_oe  = 1'b1;
        bus_d.ad_out = rtc_addr(idx_d);
      end
      ST_READ: begin
        bus_d.cs_n   = 1'b0;
        bus_d.rd_n   = 1'b0;
        bus_d.ad_sel = 1'b1;
        bus_d.ad_oe  = 1'b0;
      end
      default: begin
        bus_d = BUS_IDLE;
      end
    endcase
  end

  assign finwt  = finwt_q;
  assign busy   = busy_q;
  assign cs_n   = bus_q.cs_n;
  assign wr_n   = bus_q.wr_n;
  assign rd_n   = bus_q.rd_n;
  assign ad_sel = bus_q.ad_sel;
  assign ad_oe  = bus_q.ad_oe;
  assign ad_out = bus_q.ad_out;
  assign seg    = seg_q;
  assign min    = min_q;
  assign hora   = hora_q;

endmodule

// File: tb/tb_lectura_rtc.sv
// Purpose: checks two sequencer instances (default widths and PULSE=GAP=1) against a timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_lectura_rtc;

  localparam int P0 = 4;
  localparam int G0 = 2;
  localparam int P1 = 1;
  localparam int G1 = 1;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       whileT = 1'b0;
  logic [7:0] ad_in = 8'h00;

  logic       fin_o [2];
  logic       busy_o[2];
  logic       cs_o  [2];
  logic       wr_o  [2];
  logic       rd_o  [2];
  logic       sel_o [2];
  logic       oe_o  [2];
  logic [7:0] ad_o  [2];
  logic [7:0] seg_o [2];
  logic [7:0] min_o [2];
  logic [7:0] hora_o[2];

  int checks = 0;
  int errors = 0;
  logic chk_on = 1'b0;

  always #5 CLK = ~CLK;

  lectura_rtc dut0 (
    .CLK(CLK), .reset(reset), .whileT(whileT), .finwt(fin_o[0]), .busy(busy_o[0]),
    .cs_n(cs_o[0]), .wr_n(wr_o[0]), .rd_n(rd_o[0]), .ad_sel(sel_o[0]), .ad_oe(oe_o[0]),
    .ad_out(ad_o[0]), .ad_in(ad_in), .seg(seg_o[0]), .min(min_o[0]), .hora(hora_o[0])
  );

  lectura_rtc #(.PULSE(P1), .GAP(G1)) dut1 (
    .CLK(CLK), .reset(reset), .whileT(whileT), .finwt(fin_o[1]), .busy(busy_o[1]),
    .cs_n(cs_o[1]), .wr_n(wr_o[1]), .rd_n(rd_o[1]), .ad_sel(sel_o[1]), .ad_oe(oe_o[1]),
    .ad_out(ad_o[1]), .ad_in(ad_in), .seg(seg_o[1]), .min(min_o[1]), .hora(hora_o[1])
  );

  task automatic chk(input string nm, input int inst, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, inst, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running (n = cycles since the start edge), 2 waiting for whileT to drop.
  int         mode[2] = '{0, 0};
  int         n[2]    = '{0, 0};
  logic [7:0] cap[2][3];

  function automatic int pw(input int i);
    return (i == 0) ? P0 : P1;
  endfunction

  function automatic int gw(input int i);
    return (i == 0) ? G0 : G1;
  endfunction

  function automatic int seglen(input int i);
    return 2 * pw(i) + 2 * gw(i);
  endfunction

  // 0 address, 1 turnaround, 2 read, 3 gap, 4 done pulse, 5 quiet.
  function automatic int phase_of(input int i, input int md, input int off);
    int r;
    if (md != 1) return 5;
    if (off >= 3 * seglen(i)) return 4;
    r = off % seglen(i);
    if (r < pw(i)) return 0;
    if (r < pw(i) + gw(i)) return 1;
    if (r < 2 * pw(i) + gw(i)) return 2;
    return 3;
  endfunction

  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        mode[i] <= 0;
        n[i]    <= 0;
        for (int j = 0; j < 3; j++) cap[i][j] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (mode[i])
          0: if (whileT) begin
            mode[i] <= 1;
            n[i]    <= 0;
          end
          1: begin
            if (n[i] >= 3 * seglen(i)) begin
              mode[i] <= 2;
            end else begin
              if (phase_of(i, 1, n[i]) == 2 && phase_of(i, 1, n[i] + 1) != 2)
                cap[i][n[i] / seglen(i)] <= ad_in;
              n[i] <= n[i] + 1;
            end
          end
          default: if (!whileT) mode[i] <= 0;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        int ph;
        logic [7:0] ea;
        ph = phase_of(i, mode[i], n[i]);
        ea = 8'h21 + 8'(n[i] / seglen(i));
        chk("busy",  i, 8'(busy_o[i]), 8'(mode[i] != 0));
        chk("finwt", i, 8'(fin_o[i]),  8'(ph == 4));
        chk("cs_n",  i, 8'(cs_o[i]),   8'(!(ph == 0 || ph == 2)));
        chk("wr_n",  i, 8'(wr_o[i]),   8'(ph != 0));
        chk("rd_n",  i, 8'(rd_o[i]),   8'(ph != 2));
        chk("ad_oe", i, 8'(oe_o[i]),   8'(ph == 0));
        if (ph == 0) begin
          chk("ad_out", i, ad_o[i], ea);
          chk("ad_sel_addr", i, 8'(sel_o[i]), 8'h00);
        end
        if (ph == 2) chk("ad_sel_read", i, 8'(sel_o[i]), 8'h01);
        chk("seg",  i, seg_o[i],  cap[i][0]);
        chk("min",  i, min_o[i],  cap[i][1]);
        chk("hora", i, hora_o[i], cap[i][2]);
        chk("rd_wr_overlap", i, 8'(!rd_o[i] && !wr_o[i]), 8'h00);
        chk("oe_during_rd",  i, 8'(oe_o[i] && !rd_o[i]), 8'h00);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] tbl[3];
  int fin_cnt, fin_at, fin1_at, cs_extra;

  initial begin
    tbl[0] = 8'h45;
    tbl[1] = 8'h30;
    tbl[2] = 8'h12;

    // Reset state.
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 0, 8'(busy_o[0]), 8'h00);
    chk("rst_cs_n", 0, 8'(cs_o[0]),   8'h01);
    chk("rst_rd_n", 0, 8'(rd_o[0]),   8'h01);
    chk("rst_seg",  0, seg_o[0],      8'h00);
    chk_on = 1'b1;
    #1 reset = 1'b1;

    // Directed read: 0x45 / 0x30 / 0x12, whileT kept high well past finwt.
    @(posedge CLK);
    #2 whileT = 1'b1;
    @(posedge CLK);  // start edge
    fin_cnt = 0; fin_at = -1; fin1_at = -1; cs_extra = 0;
    for (int o = 0; o < 44; o++) begin
      #2;
      ad_in = tbl[(o / 12 > 2) ? 2 : o / 12];
      if (fin_o[0]) begin fin_cnt++; fin_at = o; end
      if (fin_o[1]) fin1_at = o;
      if (o > 36 && !cs_o[0]) cs_extra++;
      @(posedge CLK);
    end
    chk("fin_count",   0, 8'(fin_cnt),  8'd1);
    chk("fin_latency", 0, 8'(fin_at),   8'd36);
    chk("fin_latency", 1, 8'(fin1_at),  8'd12);
    chk("no_rearm",    0, 8'(cs_extra), 8'd0);
    chk("lit_seg",  0, seg_o[0],  8'h45);
    chk("lit_min",  0, min_o[0],  8'h30);
    chk("lit_hora", 0, hora_o[0], 8'h12);

    // Drop and re-raise whileT, then reset during the second READ.
    #2 whileT = 1'b0;
    repeat (3) @(posedge CLK);
    #2 whileT = 1'b1;
    @(posedge CLK);  // start edge
    for (int o = 0; o < 19; o++) begin
      #2 ad_in = 8'($urandom);
      @(posedge CLK);
    end
    #2 reset = 1'b0;
    whileT = 1'b0;
    #1;
    chk("abort_busy",  0, 8'(busy_o[0]), 8'h00);
    chk("abort_cs_n",  0, 8'(cs_o[0]),   8'h01);
    chk("abort_rd_n",  0, 8'(rd_o[0]),   8'h01);
    chk("abort_finwt", 0, 8'(fin_o[0]),  8'h00);
    chk("abort_seg",   0, seg_o[0],      8'h00);
    chk("abort_min",   0, min_o[0],      8'h00);
    repeat (2) @(posedge CLK);
    #2 reset = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    chk("post_busy", 0, 8'(busy_o[0]), 8'h00);
    chk("post_min",  0, min_o[0],      8'h00);

    // Random traffic: request toggling, random read data, rare reset pulses.
    for (int c = 0; c < 2000; c++) begin
      @(posedge CLK);
      #2;
      ad_in = 8'($urandom);
      if ($urandom_range(0, 29) == 0) whileT = ~whileT;
      reset = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
    end
    #2 reset = 1'b1;
    repeat (2) @(posedge CLK);
    chk_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
